csr_trap_controller: RTL

Sequencer and single-port arbiter in front of the 4096-entry machine-mode CSR register file. It serialises pipeline CSR instructions (CSRRW/RS/RC and immediate forms), synchronous exceptions, `mret` and an optional external interrupt onto one CSR access port. It performs the multi-cycle trap-entry and trap-return CSR updates, and issues a PC redirect to the fetch stage. It sits between the EX/MEM stage, the CSR register file and the PC mux.

---
 rtl/csr_trap_controller.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/csr_trap_controller.sv
// Single-port CSR sequencer: CSR instructions, trap entry, mret and redirect.
// Define CSR_IRQ_EN to add the external interrupt path and its MIE/MEIE shadows.
module csr_trap_controller #(
  parameter int unsigned TVEC_ALIGN = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        op_valid_i,
  input  logic [2:0]  op_type_i,
  input  logic [11:0] op_addr_i,
  input  logic [31:0] op_rs1_i,
  input  logic [4:0]  op_zimm_i,
  output logic        op_ack_o,
  output logic [31:0] op_result_o,
  input  logic        exc_valid_i,
  input  logic [30:0] exc_cause_i,
  input  logic [31:0] exc_pc_i,
  input  logic        mret_valid_i,
  input  logic        irq_ext_i,
  input  logic [31:0] irq_pc_i,
  output logic [11:0] csr_addr_o,
  output logic        csr_we_o,
  output logic [31:0] csr_wdata_o,
  input  logic [31:0] csr_rdata_i,
  output logic        stall_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o
);

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [31:0] IRQ_CAUSE    = 32'h8000_000B;
  localparam logic [31:0] VEC_MASK     = ~(TVEC_ALIGN - 32'd1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    T_EPC    = 3'd1,
    T_CAUSE  = 3'd2,
    T_STATUS = 3'd3,
    T_VEC    = 3'd4,
    R_STATUS = 3'd5,
    R_EPC    = 3'd6
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] operand_s;
  logic        irq_take_s;

  function automatic logic [31:0] trap_status(input logic [31:0] ms);
    logic [31:0] r;
    r    = ms;
    r[7] = ms[3];
    r[3] = 1'b0;
    return r;
  endfunction

  function automatic logic [31:0] ret_status(input logic [31:0] ms);
    logic [31:0] r;
    r    = ms;
    r[3] = ms[7];
    r[7] = 1'b1;
    return r;
  endfunction

`ifdef CSR_IRQ_EN
  localparam logic [11:0] ADDR_MIE = 12'h304;
  logic sh_mie_q;
  logic sh_meie_q;

  assign irq_take_s = irq_ext_i & sh_mie_q & sh_meie_q;

  // Shadow MIE/MEIE snooped from every port write, including trap/return writes
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sh_mie_q  <= 1'b0;
      sh_meie_q <= 1'b0;
    end else begin
      if (csr_we_o && (csr_addr_o == ADDR_MSTATUS)) sh_mie_q <= csr_wdata_o[3];
      if (csr_we_o && (csr_addr_o == ADDR_MIE))     sh_meie_q <= csr_wdata_o[11];
    end
  end
`else
  logic unused_irq_s;
  assign unused_irq_s = ^{irq_ext_i, irq_pc_i};
  assign irq_take_s   = 1'b0;
`endif

  // Event arbitration, CSR port drive and next-state selection
  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    cause_d          = cause_q;
    operand_s        = op_type_i[2] ? {27'd0, op_zimm_i} : op_rs1_i;
    csr_addr_o       = 12'h000;
    csr_we_o         = 1'b0;
    csr_wdata_o      = 32'h0000_0000;
    op_ack_o         = 1'b0;
    op_result_o      = 32'h0000_0000;
    stall_o          = 1'b1;
    redirect_valid_o = 1'b0;
    redirect_pc_o    = 32'h0000_0000;
    case (state_q)
      IDLE: begin
        if (exc_valid_i) begin
          pc_d    = exc_pc_i;
          cause_d = {1'b0, exc_cause_i};
          state_d = T_EPC;
        end else if (mret_valid_i) begin
          state_d = R_STATUS;
        end else if (irq_take_s) begin
          pc_d    = irq_pc_i;
          cause_d = IRQ_CAUSE;
          state_d = T_EPC;
        end else begin
          stall_o = 1'b0;
          if (op_valid_i) begin
            op_ack_o = 1'b1;
            // Set/clear forms with a zero operand read without writing
            case (op_type_i)
              3'b001, 3'b101: begin
                csr_addr_o  = op_addr_i;
                op_result_o = csr_rdata_i;
                csr_we_o    = 1'b1;
                csr_wdata_o = operand_s;
              end
              3'b010, 3'b110: begin
                csr_addr_o  = op_addr_i;
                op_result_o = csr_rdata_i;
                csr_we_o    = (operand_s != 32'h0000_0000);
                csr_wdata_o = csr_rdata_i | operand_s;
              end
              3'b011, 3'b111: begin
                csr_addr_o  = op_addr_i;
                op_result_o = csr_rdata_i;
                csr_we_o    = (operand_s != 32'h0000_0000);
                csr_wdata_o = csr_rdata_i & ~operand_s;
              end
              default: begin
                op_result_o = 32'h0000_0000;
              end
            endcase
          end else begin
            op_ack_o = 1'b0;
          end
        end
      end
      T_EPC: begin
        csr_addr_o  = ADDR_MEPC;
        csr_we_o    = 1'b1;
        csr_wdata_o = {pc_q[31:2], 2'b00};
        state_d     = T_CAUSE;
      end
      T_CAUSE: begin
        csr_addr_o  = ADDR_MCAUSE;
        csr_we_o    = 1'b1;
        csr_wdata_o = cause_q;
        state_d     = T_STATUS;
      end
      T_STATUS: begin
        csr_addr_o  = ADDR_MSTATUS;
        csr_we_o    = 1'b1;
        csr_wdata_o = trap_status(csr_rdata_i);
        state_d     = T_VEC;
      end
      T_VEC: begin
        csr_addr_o       = ADDR_MTVEC;
        redirect_valid_o = 1'b1;
        redirect_pc_o    = csr_rdata_i & VEC_MASK;
        state_d          = IDLE;
      end
      R_STATUS: begin
        csr_addr_o  = ADDR_MSTATUS;
        csr_we_o    = 1'b1;
        csr_wdata_o = ret_status(csr_rdata_i);
        state_d     = R_EPC;
      end
      R_EPC: begin
        csr_addr_o       = ADDR_MEPC;
        redirect_valid_o = 1'b1;
        redirect_pc_o    = csr_rdata_i;
        state_d          = IDLE;
      end
      default: begin
        stall_o = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Sequencer state plus latched trap PC and cause
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      pc_q    <= 32'h0000_0000;
      cause_q <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cause_q <= cause_d;
    end
  end

endmodule
